// File: rtl/riscv_run_pkg.sv
// Shared types for the run monitor: FSM state encodings and a width helper.
// Imported by riscv_run_monitor and riscv_pc_trace_buf.
package riscv_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_e;

    // Bits needed to index 'value' entries; never less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/riscv_pc_trace_buf.sv
// Circular buffer of the most recent PCs. Ports: wr_en/wr_pc write one entry,
// clr zeroes all entries and the pointer, rd_idx (0 = newest) selects rd_pc.
module riscv_pc_trace_buf
    import riscv_run_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_pc,
    input  logic                      clr,
    input  logic [clog2(DEPTH)-1:0]   rd_idx,
    output logic [ADDR_W-1:0]         rd_pc
);

    localparam int IW = clog2(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [IW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]     rd_ptr;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            wr_ptr_d = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_pc;
            wr_ptr_d        = wr_ptr_q + IW'(1);
        end
    end

    // Newest entry sits just behind the write pointer.
    assign rd_ptr = wr_ptr_q - IW'(1) - rd_idx;
    assign rd_pc  = mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller for the core: releases core reset after a start pulse, counts
// RUN cycles, and ends the run on END_ADDR, a stalled PC, or the cycle budget.
// Ports: start/abort control, pc_i observed PC, core_rst_n to the core,
// running/done/timeout status, halt_pc, cycle_cnt, trace_idx/trace_pc.
// Option: define RUN_TRACE_EN to add the PC trace buffer (else trace_pc = 0).
module riscv_run_monitor
    import riscv_run_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                CNT_W       = 16,
    parameter int                RST_CYCLES  = 4,
    parameter int                MAX_CYCLES  = 1000,
    parameter int                STALL_LIMIT = 8,
    parameter logic [ADDR_W-1:0] END_ADDR    = 8'hFC,
    parameter int                TRACE_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [ADDR_W-1:0]               pc_i,
    output logic                            core_rst_n,
    output logic                            running,
    output logic                            done,
    output logic                            timeout,
    output logic [ADDR_W-1:0]               halt_pc,
    output logic [CNT_W-1:0]                cycle_cnt,
    input  logic [clog2(TRACE_DEPTH)-1:0]   trace_idx,
    output logic [ADDR_W-1:0]               trace_pc
);

    localparam int RW = clog2(RST_CYCLES);
    localparam int SW = clog2(STALL_LIMIT);
    localparam logic [RW-1:0]    RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    run_state_e        state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
    logic              first_q, first_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              pc_same;
    logic              halt;

    // No previous sample exists on the first RUN cycle.
    assign pc_same = (pc_i == prev_pc_q) & ~first_q;
    assign halt    = (pc_i == END_ADDR)
                   | (pc_same & (stall_cnt_q == STALL_LAST));

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        prev_pc_d   = prev_pc_q;
        halt_pc_d   = halt_pc_q;
        first_d     = first_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) begin
                        state_d     = ST_RESET;
                        rst_cnt_d   = '0;
                        cycle_cnt_d = '0;
                        stall_cnt_d = '0;
                        halt_pc_d   = '0;
                    end
                end
                ST_RESET: begin
                    first_d = 1'b1;
                    if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
                    else rst_cnt_d = rst_cnt_q + RW'(1);
                end
                ST_RUN: begin
                    if (cycle_cnt_q != CNT_SAT)
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    first_d     = 1'b0;
                    prev_pc_d   = pc_i;
                    stall_cnt_d = pc_same ? stall_cnt_q + SW'(1) : '0;
                    if (halt) begin
                        state_d   = ST_DONE;
                        halt_pc_d = pc_i;
                    end else if (cycle_cnt_q == CNT_LAST) begin
                        state_d   = ST_TIMEOUT;
                        halt_pc_d = pc_i;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        core_rst_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            prev_pc_q    <= '0;
            halt_pc_q    <= '0;
            first_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            prev_pc_q    <= prev_pc_d;
            halt_pc_q    <= halt_pc_d;
            first_q      <= first_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign running    = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign timeout    = (state_q == ST_TIMEOUT);
    assign halt_pc    = halt_pc_q;
    assign cycle_cnt  = cycle_cnt_q;

`ifdef RUN_TRACE_EN
    logic trace_wr;
    logic trace_clr;

    assign trace_wr  = running & ~pc_same;
    assign trace_clr = (state_d == ST_RESET) & (state_q != ST_RESET);

    riscv_pc_trace_buf #(
        .DEPTH  (TRACE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_trace (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (trace_wr),
        .wr_pc  (pc_i),
        .clr    (trace_clr),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc)
    );
`else
    logic trace_unused;

    assign trace_unused = ^trace_idx;
    assign trace_pc     = '0;
`endif

endmodule
